// File: rtl/uart_pkg.sv
// uart_pkg: shared states, frame status codes and constants for the UART receive path
package uart_pkg;
   typedef enum logic [2:0] {HUNT, LEN, DATA, CHK, DONE} deframer_state_t;
   typedef enum logic [1:0] {ERR_OK = 2'd0, ERR_CHK = 2'd1, ERR_LEN = 2'd2, ERR_TO = 2'd3} frame_err_t;
   localparam logic [7:0] SOF_DEFAULT = 8'h7E;
endpackage

// File: rtl/deframer_timeout.sv
// deframer_timeout: inter-byte idle counter with clear, enable and expire flag
module deframer_timeout #(
   parameter int TO_WORD     = 16,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   logic [TO_WORD-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
   // raised one cycle ahead so the DONE cycle is the TIMEOUT_CYC-th cycle after the last pop
   assign expire_o = en_i & ~clr_i & (cnt_q == TO_WORD'(TIMEOUT_CYC - 2));
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: pops RX FIFO bytes, parses SOF/len/payload/checksum frames and streams the payload
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter logic [7:0] SOF         = SOF_DEFAULT,
   parameter int         MAX_LEN     = 64,
   parameter int         TO_WORD     = 16,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rxAvail_i,
   input  logic [7:0]  rxDat_i,
   output logic        rxRd_o,
   output logic        pldValid_o,
   output logic [7:0]  pldDat_o,
   output logic        pldLast_o,
   input  logic        pldReady_i,
   output logic        frmDone_o,
   output logic [1:0]  frmErr_o,
   output logic [15:0] goodCnt_o,
   output logic [7:0]  errCnt_o
);
   localparam logic [7:0] MAX_B = 8'(MAX_LEN);
   deframer_state_t state_q, state_d;
   frame_err_t      err_q, err_d;
   logic [7:0]      acc_q, acc_d, rem_q, rem_d, dat_q, dat_d, err_cnt_q, err_cnt_d;
   logic [15:0]     good_cnt_q, good_cnt_d;
   logic            vld_q, vld_d, last_q, last_d;
   logic            pop, accept, expire, in_frame;
   logic [7:0]      acc_sum;
   assign in_frame = state_q inside {LEN, DATA, CHK};
   assign accept   = vld_q & pldReady_i;
   assign pop      = ~rst_i & rxAvail_i &
                     ((state_q inside {HUNT, LEN, CHK}) | ((state_q == DATA) & (~vld_q | pldReady_i)));
   assign acc_sum  = acc_q + rxDat_i;
   deframer_timeout #(.TO_WORD(TO_WORD), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (pop | (state_q == HUNT)),
      .en_i     (in_frame),
      .expire_o (expire)
   );
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      dat_d      = dat_q;
      vld_d      = vld_q & ~accept;
      last_d     = last_q & ~accept;
      good_cnt_d = good_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (expire) begin
         state_d = DONE;
         err_d   = ERR_TO;
      end else begin
         case (state_q)
            HUNT: if (pop && rxDat_i == SOF) begin
               state_d = LEN;
               acc_d   = '0;
            end
            LEN: if (pop) begin
               acc_d   = acc_sum;
               rem_d   = rxDat_i;
               err_d   = ERR_LEN;
               state_d = (rxDat_i == 8'd0 || rxDat_i > MAX_B) ? DONE : DATA;
            end
            DATA: if (pop) begin
               acc_d   = acc_sum;
               rem_d   = rem_q - 8'd1;
               dat_d   = rxDat_i;
               vld_d   = 1'b1;
               last_d  = rem_q == 8'd1;
               state_d = (rem_q == 8'd1) ? CHK : DATA;
            end
            CHK: if (pop) begin
               state_d = DONE;
               err_d   = (acc_sum == 8'd0) ? ERR_OK : ERR_CHK;
            end
            DONE: begin
               state_d = HUNT;
               if (err_q == ERR_OK) good_cnt_d = good_cnt_q + 16'd1;
               else                 err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end
            default: state_d = HUNT;
         endcase
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= HUNT;
         err_q      <= ERR_OK;
         acc_q      <= '0;
         rem_q      <= '0;
         dat_q      <= '0;
         vld_q      <= 1'b0;
         last_q     <= 1'b0;
         good_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         acc_q      <= acc_d;
         rem_q      <= rem_d;
         dat_q      <= dat_d;
         vld_q      <= vld_d;
         last_q     <= last_d;
         good_cnt_q <= good_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end
   assign rxRd_o     = pop;
   assign pldValid_o = vld_q;
   assign pldDat_o   = dat_q;
   assign pldLast_o  = last_q;
   assign frmDone_o  = state_q == DONE;
   assign frmErr_o   = err_q;
   assign goodCnt_o  = good_cnt_q;
   assign errCnt_o   = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed and randomized frames checked against a frame-level reference model
module tb_uart_rx_deframer;
   localparam int TO = 20;
   logic        clk_i = 1'b0, rst_i, rxAvail_i, rxRd_o, pldValid_o, pldLast_o, pldReady_i, frmDone_o;
   logic [7:0]  rxDat_i, pldDat_o, errCnt_o;
   logic [1:0]  frmErr_o;
   logic [15:0] goodCnt_o;
   int          n_checks = 0, n_fail = 0;
   logic [7:0]  fifo[$];
   logic [8:0]  exp_pld[$];
   logic [1:0]  exp_err[$];
   int          acc_cyc[$];
   int          good_exp = 0, err_exp = 0, cyc = 0, last_pop_cyc = 0, done_cyc = 0;
   int          ready_pct = 100, avail_pct = 100, stall_left = 0;
   bit          bp_mode = 0, bp_started = 0;
   always #5 clk_i = ~clk_i;
   uart_rx_deframer #(.TIMEOUT_CYC(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rxAvail_i(rxAvail_i), .rxDat_i(rxDat_i), .rxRd_o(rxRd_o),
      .pldValid_o(pldValid_o), .pldDat_o(pldDat_o), .pldLast_o(pldLast_o), .pldReady_i(pldReady_i),
      .frmDone_o(frmDone_o), .frmErr_o(frmErr_o), .goodCnt_o(goodCnt_o), .errCnt_o(errCnt_o)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // frame-level reference: walks the byte stream and lists the payload and status it must produce
   task automatic model(input logic [7:0] s[$]);
      int i = 0;
      int len, sum;
      while (i < s.size()) begin
         if (s[i] != 8'h7E) begin
            i++;
            continue;
         end
         if (i + 1 >= s.size()) break;
         len = int'(s[i+1]);
         i += 2;
         if (len == 0 || len > 64) begin
            exp_err.push_back(2'd2);
            err_exp = (err_exp < 255) ? err_exp + 1 : 255;
            continue;
         end
         if (i + len >= s.size()) break;
         sum = len;
         for (int k = 0; k < len; k++) begin
            exp_pld.push_back({(k == len - 1), s[i+k]});
            sum += int'(s[i+k]);
         end
         sum += int'(s[i+len]);
         if (sum % 256 == 0) begin
            exp_err.push_back(2'd0);
            good_exp = (good_exp + 1) % 65536;
         end else begin
            exp_err.push_back(2'd1);
            err_exp = (err_exp < 255) ? err_exp + 1 : 255;
         end
         i += len + 1;
      end
   endtask
   task automatic send(input logic [7:0] b[$]);
      foreach (b[k]) fifo.push_back(b[k]);
      model(b);
   endtask
   task automatic tick();
      bit popped;
      @(negedge clk_i);
      rxAvail_i = fifo.size() > 0 && ($urandom_range(99) < avail_pct);
      rxDat_i   = fifo.size() > 0 ? fifo[0] : 8'h00;
      #1;
      if (bp_mode && pldValid_o && !bp_started) begin
         bp_started = 1;
         stall_left = 5;
      end
      pldReady_i = stall_left > 0 ? 1'b0 : ($urandom_range(99) < ready_pct);
      #1;
      cyc++;
      if (stall_left > 0) begin
         check("bp_hold_dat", pldDat_o, 8'h11);
         check("bp_no_pop", rxRd_o, 0);
         stall_left--;
      end
      popped = rxRd_o;
      if (popped) last_pop_cyc = cyc;
      if (pldValid_o && pldReady_i) begin
         acc_cyc.push_back(cyc);
         if (exp_pld.size() == 0) check("pld_unexpected", exp_pld.size(), 1);
         else check("pld_byte", {pldLast_o, pldDat_o}, exp_pld.pop_front());
      end
      if (frmDone_o) begin
         done_cyc = cyc;
         if (exp_err.size() == 0) check("done_unexpected", exp_err.size(), 1);
         else check("frm_err", frmErr_o, exp_err.pop_front());
      end
      @(posedge clk_i);
      if (popped) void'(fifo.pop_front());
   endtask
   task automatic drain(input int budget);
      int n = 0;
      while ((fifo.size() > 0 || exp_pld.size() > 0 || exp_err.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_left", fifo.size() + exp_pld.size() + exp_err.size(), 0);
      repeat (3) tick();
      check("good_cnt", goodCnt_o, good_exp);
      check("err_cnt", errCnt_o, err_exp);
   endtask
   initial begin
      logic [7:0] b[$];
      logic [7:0] j;
      int len, sum, n;
      rst_i = 1; rxAvail_i = 0; rxDat_i = 0; pldReady_i = 1;
      repeat (2) @(negedge clk_i);
      check("rst_outs", {rxRd_o, pldValid_o, pldDat_o, pldLast_o, frmDone_o, frmErr_o}, 0);
      check("rst_cnts", {goodCnt_o, errCnt_o}, 0);
      rst_i = 0;
      acc_cyc.delete();
      b = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
      send(b);
      drain(200);
      check("good_n_bytes", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) check("good_b2b", acc_cyc[2] - acc_cyc[0], 2);
      b = {8'h7E, 8'h02, 8'hAA, 8'hBB, 8'h00};
      send(b);
      drain(200);
      acc_cyc.delete();
      b = {8'h55, 8'h7E, 8'h00};
      send(b);
      drain(200);
      b = {8'h7E, 8'h41};
      send(b);
      drain(200);
      check("len_err_no_pld", acc_cyc.size(), 0);
      bp_mode = 1; bp_started = 0;
      b = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
      send(b);
      drain(200);
      check("bp_seen", bp_started, 1);
      bp_mode = 0;
      fifo.push_back(8'h7E); fifo.push_back(8'h04); fifo.push_back(8'h01);
      exp_pld.push_back({1'b0, 8'h01});
      exp_err.push_back(2'd3);
      err_exp++;
      drain(200);
      check("to_latency", done_cyc - last_pop_cyc, TO);
      avail_pct = 85; ready_pct = 80;
      for (int f = 0; f < 40; f++) begin
         b.delete();
         repeat ($urandom_range(2)) begin
            do j = 8'($urandom); while (j == 8'h7E);
            b.push_back(j);
         end
         if ($urandom_range(9) == 0) len = $urandom_range(1) ? 0 : int'($urandom_range(255, 65));
         else len = int'($urandom_range(64, 1));
         b.push_back(8'h7E);
         b.push_back(8'(len));
         if (len >= 1 && len <= 64) begin
            sum = len;
            for (int k = 0; k < len; k++) begin
               j = 8'($urandom);
               b.push_back(j);
               sum += int'(j);
            end
            b.push_back($urandom_range(3) == 0 ? 8'($urandom) : 8'(256 - sum % 256));
         end
         send(b);
      end
      drain(30000);
      avail_pct = 100; ready_pct = 0;
      fifo.push_back(8'h7E); fifo.push_back(8'h03); fifo.push_back(8'h11);
      n = 0;
      while (fifo.size() > 0 && n < 50) begin
         tick();
         n++;
      end
      tick();
      check("pre_rst_valid", pldValid_o, 1);
      #2 rst_i = 1;
      #1;
      check("async_rst_outs", {rxRd_o, pldValid_o, pldDat_o, pldLast_o, frmDone_o, frmErr_o}, 0);
      check("async_rst_cnts", {goodCnt_o, errCnt_o}, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 0;
      good_exp = 0; err_exp = 0; ready_pct = 100;
      repeat (5) tick();
      b = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
      send(b);
      drain(200);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
